instruction_fetch: RTL

Instruction-fetch stage plus IF/ID pipeline register. It is the producer end of the decode interface: it drives the instruction word and PC+4 that decode consumes, and accepts branch/jump redirects computed downstream. It holds a word-addressed instruction memory that is filled through a simple load handshake before execution starts. It detects the halt opcode to stop the pipeline.

---
 rtl/instruction_fetch.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Instruction-fetch stage with its IF/ID pipeline register. A word-addressed
// instruction memory is first filled through a load handshake (LOAD state).
// The stage then fetches sequentially (RUN) until a halt opcode reaches
// IF/ID (HALT). Branch and jump redirects come from later stages.
//
// Ports:
//   i_clock        rising-edge clock
//   i_reset        synchronous active-low reset
//   i_enable       run/step enable; 0 holds PC and IF/ID in RUN
//   i_stall        hazard stall; holds PC and IF/ID
//   i_pcsrc        branch taken, redirect to i_pcbranch (highest priority)
//   i_pcbranch     branch target byte address
//   i_jump         jump taken, redirect to i_pcjump
//   i_pcjump       jump target byte address
//   i_loadvalid    program word valid (LOAD only)
//   i_loaddata     program word
//   o_loadready    high while accepting program words
//   o_instruccion  IF/ID instruction register
//   o_currentpc    IF/ID PC+4 register
//   o_pc           current PC register
//   o_halt         sticky halt flag
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 64,
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_stall,
  input  logic                  i_pcsrc,
  input  logic [DATA_WIDTH-1:0] i_pcbranch,
  input  logic                  i_jump,
  input  logic [DATA_WIDTH-1:0] i_pcjump,
  input  logic                  i_loadvalid,
  input  logic [DATA_WIDTH-1:0] i_loaddata,
  output logic                  o_loadready,
  output logic [DATA_WIDTH-1:0] o_instruccion,
  output logic [DATA_WIDTH-1:0] o_currentpc,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic                  o_halt
);

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] PcStep  = DATA_WIDTH'(4);

  typedef enum logic [1:0] {StLoad, StRun, StHalt} state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] cpc_q, cpc_d;
  logic                  halt_q, halt_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;

  logic                  load_ready;
  logic                  load_we;
  logic                  load_last;
  logic [DATA_WIDTH-1:0] fetch_word;
  logic                  fetch_halt;
  logic                  redirect;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  adv;
  logic                  take_halt;
  logic [DATA_WIDTH-1:0] pc_plus4;

  function automatic logic is_halt(input logic [DATA_WIDTH-1:0] word);
    return word[DATA_WIDTH-1 -: 6] == HALT_OPCODE;
  endfunction

  // ---------------------------------------------------------------------------
  // Shared decode of the current cycle
  // ---------------------------------------------------------------------------
  // Gating with i_reset keeps loadready low (and writes off) in the reset cycle.
  assign load_ready  = (state_q == StLoad) & i_reset;
  assign load_we     = load_ready & i_loadvalid;
  assign load_last   = load_we & (is_halt(i_loaddata) | (wptr_q == LastIdx));

  // pc[1:0] is dropped; upper bits beyond the memory wrap silently.
  assign fetch_word  = mem[pc_q[ADDR_WIDTH+1:2]];
  assign fetch_halt  = is_halt(fetch_word);
  assign pc_plus4    = pc_q + PcStep;

  assign redirect    = i_pcsrc | i_jump;
  assign redirect_pc = i_pcsrc ? i_pcbranch : i_pcjump;
  assign adv         = i_enable & ~i_stall;
  // A halt fetched on a redirected (wrong-path) cycle is discarded.
  assign take_halt   = (state_q == StRun) & ~redirect & adv & fetch_halt;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= StLoad;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      StLoad:  if (load_last) state_d = StRun;
      StRun:   if (take_halt) state_d = StHalt;
      StHalt:  state_d = StHalt;
      default: state_d = StLoad;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_loadready   = load_ready;
    o_instruccion = instr_q;
    o_currentpc   = cpc_q;
    o_pc          = pc_q;
    o_halt        = halt_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state: PC, IF/ID, halt flag, load pointer
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    cpc_d   = cpc_q;
    halt_d  = halt_q;
    wptr_d  = wptr_q;
    case (state_q)
      StLoad: begin
        // IF/ID presents a NOP and PC sits at 0 until the program is in.
        pc_d    = '0;
        instr_d = '0;
        cpc_d   = '0;
        if (load_we) begin
          wptr_d = wptr_q + ADDR_WIDTH'(1);
        end
      end
      StRun: begin
        if (redirect) begin
          // Redirects override both stall and enable, and flush IF/ID.
          pc_d    = redirect_pc;
          instr_d = '0;
          cpc_d   = '0;
        end else if (adv) begin
          instr_d = fetch_word;
          cpc_d   = pc_plus4;
          if (fetch_halt) begin
            halt_d = 1'b1;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      StHalt: begin
        // PC frozen, IF/ID drains to NOP and stays there.
        instr_d = '0;
        cpc_d   = '0;
      end
      default: begin
        pc_d    = '0;
        instr_d = '0;
        cpc_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      pc_q    <= '0;
      instr_q <= '0;
      cpc_q   <= '0;
      halt_q  <= 1'b0;
      wptr_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cpc_q   <= cpc_d;
      halt_q  <= halt_d;
      wptr_q  <= wptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction memory: contents survive reset; stale words remain until
  // overwritten by a later load.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (load_we) begin
      mem[wptr_q] <= i_loaddata;
    end
  end

endmodule
